// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared types and constants for the pipeline hazard controller.
//   hz_state_e          : controller FSM states
//   TIMEOUT_CYCLES_DEF  : default memory-drain timeout in cycles
//   *_CNT_W             : widths of the drain counter and the performance counters
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      TAKE  = 2'd2
   } hz_state_e;

   localparam int TIMEOUT_CYCLES_DEF = 255;
   localparam int DRAIN_CNT_W        = 8;
   localparam int STALL_CNT_W        = 32;
   localparam int FLUSH_CNT_W        = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline stages and the hazard controller.
//   master : pipeline side, drives stage status, receives stall/flush/take requests
//   slave  : hazard controller side
// Ports carried:
//   de_valid_i, de_rs1_addr_i, de_rs2_addr_i        decode stage status
//   ex_valid_i, ex_rd_addr_i, ex_is_load_i          execute stage status
//   ex_redirect_i, ex_exception_i, ex_mret_i        execute control events
//   mem_busy_i                                      data-memory transaction outstanding
//   *_stall_o, *_flush_o                            per-stage requests
//   trap_take_o, mret_take_o, bus_timeout_o         one-cycle pulses to CSR/PC logic
//   stall_cycles_o, flush_events_o                  saturating performance counters
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic                   de_valid_i;
   logic [4:0]             de_rs1_addr_i;
   logic [4:0]             de_rs2_addr_i;
   logic                   ex_valid_i;
   logic [4:0]             ex_rd_addr_i;
   logic                   ex_is_load_i;
   logic                   ex_redirect_i;
   logic                   ex_exception_i;
   logic                   ex_mret_i;
   logic                   mem_busy_i;

   logic                   fetch_stall_o;
   logic                   decode_stall_o;
   logic                   execute_stall_o;
   logic                   fetch_flush_o;
   logic                   decode_flush_o;
   logic                   execute_flush_o;
   logic                   trap_take_o;
   logic                   mret_take_o;
   logic                   bus_timeout_o;
   logic [STALL_CNT_W-1:0] stall_cycles_o;
   logic [FLUSH_CNT_W-1:0] flush_events_o;

   modport master (
      output de_valid_i, de_rs1_addr_i, de_rs2_addr_i,
             ex_valid_i, ex_rd_addr_i, ex_is_load_i,
             ex_redirect_i, ex_exception_i, ex_mret_i, mem_busy_i,
      input  fetch_stall_o, decode_stall_o, execute_stall_o,
             fetch_flush_o, decode_flush_o, execute_flush_o,
             trap_take_o, mret_take_o, bus_timeout_o,
             stall_cycles_o, flush_events_o
   );

   modport slave (
      input  de_valid_i, de_rs1_addr_i, de_rs2_addr_i,
             ex_valid_i, ex_rd_addr_i, ex_is_load_i,
             ex_redirect_i, ex_exception_i, ex_mret_i, mem_busy_i,
      output fetch_stall_o, decode_stall_o, execute_stall_o,
             fetch_flush_o, decode_flush_o, execute_flush_o,
             trap_take_o, mret_take_o, bus_timeout_o,
             stall_cycles_o, flush_events_o
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter -- up counter that sticks at all-ones.
//   clk, rstn : clock, asynchronous active-low reset (clears count)
//   inc_en    : increment this cycle
//   count_o   : current count
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc_en,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt_q <= '0;
      else if (inc_en && (cnt_q != {WIDTH{1'b1}}))
         cnt_q <= cnt_q + WIDTH'(1);
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline stall/flush controller with trap/mret drain sequencing.
//   clk, rstn : clock, asynchronous active-low reset
//   hif       : hazard_ctrl_if.slave (stage status in, stall/flush/take requests out)
// Stall/flush/take outputs are combinational from the registered state and the
// current inputs. A trap or MRET in execute flushes everything, then waits in
// DRAIN for the data memory to go idle (bounded by TIMEOUT_CYCLES) before
// issuing the one-cycle take pulse from TAKE.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   hazard_ctrl_if.slave hif
);

   localparam logic [DRAIN_CNT_W-1:0] TMO_LIM = TIMEOUT_CYCLES[DRAIN_CNT_W-1:0];

   hz_state_e              state_q;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q;
   logic [DRAIN_CNT_W-1:0] drain_cnt_nxt;
   logic                   kind_mret_q;
   logic                   timeout_q;

   logic load_use;
   logic fs, ds, es, ff, df, ef, trap, mret, tmo;

   assign load_use = hif.ex_valid_i & hif.ex_is_load_i & (hif.ex_rd_addr_i != 5'd0) &
                     hif.de_valid_i &
                     ((hif.ex_rd_addr_i == hif.de_rs1_addr_i) |
                      (hif.ex_rd_addr_i == hif.de_rs2_addr_i));

   assign drain_cnt_nxt = drain_cnt_q + DRAIN_CNT_W'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         kind_mret_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (hif.ex_exception_i || hif.ex_mret_i) begin
                  // An exception alongside MRET is handled as a trap.
                  kind_mret_q <= hif.ex_mret_i & ~hif.ex_exception_i;
                  timeout_q   <= 1'b0;
                  drain_cnt_q <= '0;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               if (!hif.mem_busy_i) begin
                  state_q <= TAKE;
               end else begin
                  drain_cnt_q <= drain_cnt_nxt;
                  if (drain_cnt_nxt == TMO_LIM) begin
                     timeout_q <= 1'b1;
                     state_q   <= TAKE;
                  end
               end
            end
            TAKE: begin
               drain_cnt_q <= '0;
               kind_mret_q <= 1'b0;
               timeout_q   <= 1'b0;
               state_q     <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   always_comb begin
      fs = 1'b0; ds = 1'b0; es = 1'b0;
      ff = 1'b0; df = 1'b0; ef = 1'b0;
      trap = 1'b0; mret = 1'b0; tmo = 1'b0;
      case (state_q)
         RUN: begin
            if (hif.ex_exception_i || hif.ex_mret_i) begin
               ff = 1'b1; df = 1'b1; ef = 1'b1;
            end else if (hif.ex_redirect_i) begin
               ff = 1'b1; df = 1'b1;
            end else if (hif.mem_busy_i) begin
               fs = 1'b1; ds = 1'b1; es = 1'b1;
            end else if (load_use) begin
               // Execute keeps moving; decode injects the bubble.
               fs = 1'b1; ds = 1'b1;
            end
         end
         DRAIN: begin
            fs = 1'b1; ds = 1'b1; es = 1'b1;
         end
         TAKE: begin
            ff = 1'b1; df = 1'b1;
            // A timed-out MRET becomes a bus-timeout trap.
            if (timeout_q || !kind_mret_q) trap = 1'b1;
            else                           mret = 1'b1;
            tmo = timeout_q;
         end
         default: ;
      endcase
      // Outputs are quiet for as long as reset is held, whatever the inputs.
      if (!rstn) begin
         fs = 1'b0; ds = 1'b0; es = 1'b0;
         ff = 1'b0; df = 1'b0; ef = 1'b0;
         trap = 1'b0; mret = 1'b0; tmo = 1'b0;
      end
   end

   assign hif.fetch_stall_o   = fs;
   assign hif.decode_stall_o  = ds;
   assign hif.execute_stall_o = es;
   assign hif.fetch_flush_o   = ff;
   assign hif.decode_flush_o  = df;
   assign hif.execute_flush_o = ef;
   assign hif.trap_take_o     = trap;
   assign hif.mret_take_o     = mret;
   assign hif.bus_timeout_o   = tmo;

   sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .inc_en  (ds),
      .count_o (hif.stall_cycles_o)
   );

   sat_counter #(.WIDTH(FLUSH_CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .inc_en  (ff | df | ef),
      .count_o (hif.flush_events_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Expected outputs are queued when each cycle's stimulus is driven and popped
// when the combinational outputs are sampled 1 ns later (inputs change on the
// falling edge). Performance counters are tracked by a saturating model fed
// from the expected outputs.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   typedef struct packed {
      logic       dv;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       xv;
      logic [4:0] rd;
      logic       ld;
      logic       rdr;
      logic       exc;
      logic       mr;
      logic       busy;
   } in_t;

   // {fs, ds, es, ff, df, ef, trap, mret, tmo}
   typedef logic [8:0] out_t;

   typedef struct {
      in_t   i;
      out_t  o;
      string nm;
   } vec_t;

   localparam out_t O_NONE  = 9'b000_000_000;
   localparam out_t O_LU    = 9'b110_000_000;
   localparam out_t O_STALL = 9'b111_000_000;
   localparam out_t O_RDR   = 9'b000_110_000;
   localparam out_t O_FLALL = 9'b000_111_000;
   localparam out_t O_TRAP  = 9'b000_110_100;
   localparam out_t O_MRET  = 9'b000_110_010;
   localparam out_t O_TMO   = 9'b000_110_101;

   logic clk;
   logic rstn;
   hazard_ctrl_if hif ();

   hazard_ctrl #(.TIMEOUT_CYCLES(255)) dut (
      .clk  (clk),
      .rstn (rstn),
      .hif  (hif)
   );

   // Small standalone instance to see saturation happen naturally.
   logic       sc_en;
   logic [2:0] sc_cnt;
   sat_counter #(.WIDTH(3)) u_sc3 (
      .clk     (clk),
      .rstn    (rstn),
      .inc_en  (sc_en),
      .count_o (sc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_errors = 0;
   out_t   exp_q[$];
   string  nm_q[$];
   longint m_stall = 0;
   longint m_flush = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want simulation end");
      $fatal(1, "watchdog expired");
   end

   function automatic in_t mi(logic dv, logic [4:0] rs1, logic [4:0] rs2, logic xv,
                              logic [4:0] rd, logic ld, logic rdr, logic exc,
                              logic mr, logic busy);
      in_t r;
      r.dv = dv; r.rs1 = rs1; r.rs2 = rs2; r.xv = xv; r.rd = rd;
      r.ld = ld; r.rdr = rdr; r.exc = exc; r.mr = mr; r.busy = busy;
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   function automatic out_t get_out();
      return {hif.fetch_stall_o, hif.decode_stall_o, hif.execute_stall_o,
              hif.fetch_flush_o, hif.decode_flush_o, hif.execute_flush_o,
              hif.trap_take_o, hif.mret_take_o, hif.bus_timeout_o};
   endfunction

   task automatic apply(in_t i);
      hif.de_valid_i     = i.dv;
      hif.de_rs1_addr_i  = i.rs1;
      hif.de_rs2_addr_i  = i.rs2;
      hif.ex_valid_i     = i.xv;
      hif.ex_rd_addr_i   = i.rd;
      hif.ex_is_load_i   = i.ld;
      hif.ex_redirect_i  = i.rdr;
      hif.ex_exception_i = i.exc;
      hif.ex_mret_i      = i.mr;
      hif.mem_busy_i     = i.busy;
   endtask

   // One clock cycle: called just after a falling edge, returns at the next one.
   task automatic step(in_t i, out_t e, string nm);
      out_t  want;
      string wnm;
      apply(i);
      exp_q.push_back(e);
      nm_q.push_back(nm);
      #1;
      want = exp_q.pop_front();
      wnm  = nm_q.pop_front();
      chk({wnm, " outputs"}, 64'(get_out()), 64'(want));
      chk({wnm, " stall_cycles"}, 64'(hif.stall_cycles_o), 64'(m_stall));
      chk({wnm, " flush_events"}, 64'(hif.flush_events_o), 64'(m_flush));
      if (want[7] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if ((|want[5:3]) && m_flush < 64'hFFFF) m_flush++;
      @(negedge clk);
   endtask

   task automatic chk_reset_quiet(string nm);
      #1;
      chk({nm, " outputs"}, 64'(get_out()), 64'(O_NONE));
      chk({nm, " stall_cycles"}, 64'(hif.stall_cycles_o), 64'd0);
      chk({nm, " flush_events"}, 64'(hif.flush_events_o), 64'd0);
   endtask

   vec_t vecs[14];
   in_t  I0, LU;

   initial begin
      I0 = '0;
      LU = mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 0, 0, 0, 0);   // ex LW x5 / de ADD x6,x5,x1
      vecs[0]  = '{LU,                                      O_LU,    "lu_rs1_first_after_reset"};
      vecs[1]  = '{I0,                                      O_NONE,  "lu_clears_next_cycle"};
      vecs[2]  = '{mi(1, 5'd1, 5'd5, 1, 5'd5, 1, 0, 0, 0, 0), O_LU,  "lu_rs2"};
      vecs[3]  = '{mi(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0), O_NONE,"lu_rd_x0"};
      vecs[4]  = '{mi(1, 5'd5, 5'd1, 1, 5'd5, 0, 0, 0, 0, 0), O_NONE,"not_load"};
      vecs[5]  = '{mi(0, 5'd5, 5'd1, 1, 5'd5, 1, 0, 0, 0, 0), O_NONE,"de_invalid"};
      vecs[6]  = '{mi(1, 5'd5, 5'd1, 0, 5'd5, 1, 0, 0, 0, 0), O_NONE,"ex_invalid"};
      vecs[7]  = '{mi(1, 5'd7, 5'd8, 1, 5'd5, 1, 0, 0, 0, 0), O_NONE,"no_match"};
      vecs[8]  = '{mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0), O_RDR, "redirect"};
      vecs[9]  = '{mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 1, 0, 0, 0), O_RDR, "redirect_over_lu"};
      vecs[10] = '{mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_STALL,"mem_busy"};
      vecs[11] = '{mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 0, 0, 0, 1), O_STALL,"busy_over_lu"};
      vecs[12] = '{mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1), O_RDR, "redirect_over_busy"};
      vecs[13] = '{I0,                                      O_NONE,  "idle"};

      rstn  = 1'b0;
      sc_en = 1'b0;
      // Reset holds everything quiet even with every event input active.
      apply(mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 1, 1, 1, 1));
      repeat (2) @(negedge clk);
      chk_reset_quiet("reset_state");
      @(negedge clk);
      rstn = 1'b1;

      for (int k = 0; k < 14; k++) step(vecs[k].i, vecs[k].o, vecs[k].nm);

      // Trap with memory drain: busy cycles 0..2, take pulse in cycle 4.
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1), O_FLALL, "trap_c0");
      step(mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 1, 1, 1, 1), O_STALL, "trap_c1_ignores");
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_STALL, "trap_c2");
      step(I0, O_STALL, "trap_c3");
      step(I0, O_TRAP,  "trap_c4_take");
      step(I0, O_NONE,  "trap_c5");

      // MRET with idle memory.
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0), O_FLALL, "mret_c0");
      step(I0, O_STALL, "mret_c1");
      step(mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 1, 0, 0, 0), O_MRET, "mret_take_ignores");
      step(I0, O_NONE,  "mret_after");

      // MRET with memory stuck busy: bus-timeout trap after 255 drain cycles.
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1), O_FLALL, "tmo_c0");
      for (int k = 1; k <= 255; k++)
         step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_STALL, "tmo_drain");
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_TMO, "tmo_take");
      step(I0, O_NONE, "tmo_after");

      // Exception wins over redirect and load-use; then reset mid-drain.
      step(mi(1, 5'd5, 5'd1, 1, 5'd5, 1, 1, 1, 0, 0), O_FLALL, "exc_priority");
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_STALL, "pre_rst_drain1");
      step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_STALL, "pre_rst_drain2");
      rstn = 1'b0;
      m_stall = 0;
      m_flush = 0;
      chk_reset_quiet("rst_mid_drain");
      @(negedge clk);
      apply(I0);
      chk_reset_quiet("rst_mid_drain_held");
      @(negedge clk);
      rstn = 1'b1;
      step(I0, O_NONE, "after_rst_no_take");
      step(LU, O_LU,   "after_rst_lu");
      step(I0, O_NONE, "after_rst_idle");

      // Stall counter saturation: preload near the top, then keep stalling.
      force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
      #1;
      release dut.u_stall_cnt.cnt_q;
      m_stall = 64'hFFFF_FFFD;
      for (int k = 0; k < 5; k++)
         step(mi(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1), O_STALL, "stall_sat");
      #1;
      chk("stall_cycles_saturated", 64'(hif.stall_cycles_o), 64'hFFFF_FFFF);
      @(negedge clk);

      // Narrow counter counts up and sticks at 7.
      apply(I0);
      chk("sc3_start", 64'(sc_cnt), 64'd0);
      sc_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("sc3_count3", 64'(sc_cnt), 64'd3);
      repeat (7) @(negedge clk);
      chk("sc3_saturated", 64'(sc_cnt), 64'd7);
      sc_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
